// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, D = A - B computed LSB-first.
// One full-subtractor cell per clock with a registered borrow; operands and result
// move over valid/ready handshakes. Define SERIAL_SUB_OVF_EN to add the signed
// overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;

  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_bout;

  logic             w_run;
  logic             w_last;
  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_borrow_nxt;

  // Full-subtractor cell on the current operand LSBs
  assign w_a0         = r_a_sh[0];
  assign w_b0         = r_b_sh[0];
  assign w_d          = w_a0 ^ w_b0 ^ r_borrow;
  assign w_borrow_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
  assign w_run        = (r_state == S_RUN);
  assign w_last       = (r_cnt == CW'(WIDTH - 1));

  // Next-state decode; operands are loaded only on an IDLE handshake
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; handshake/status flags registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_RUN);
    end
  end

  // Operand shifters, borrow chain, bit counter and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_bout   <= 1'b0;
    end else if (w_load) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_res    <= {w_d, r_res[WIDTH-1:1]};
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_borrow <= w_borrow_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_bout <= w_borrow_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign bits kept for overflow; w_d on the last bit is the result sign
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_run && w_last) begin
      r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign diff      = r_res;
  assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor against
// an arithmetic reference model. Main instance WIDTH=8; extra instances WIDTH=2/16.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout),
    .busy      (busy)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned difference modulo 2^W and borrow = (A < B)
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r += (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

`ifdef SERIAL_SUB_OVF_EN
  // Reference: signed result falls outside the W-bit two's-complement range
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return (r > 127) || (r < -128);
  endfunction
`endif

  // One operation: optional gap, handshake, wait result, optional backpressure, consume
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int gap, input int rdy_dly, input bit junk,
                       output logic [W-1:0] d, output logic bo, output logic ov,
                       output int lat, output bit ctl_ok);
    int t;
    ctl_ok = 1'b1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ctl_ok = 1'b0;
      if (junk) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) ctl_ok = 1'b0;
    d  = diff;
    bo = bout;
`ifdef SERIAL_SUB_OVF_EN
    ov = ovf;
`else
    ov = 1'b0;
`endif
    repeat (rdy_dly) begin
      if (junk) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
      if (!out_valid || in_ready || diff !== d || bout !== bo) ctl_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (out_valid || !in_ready || busy) ctl_ok = 1'b0;
  endtask

  // Extra widths: independent instances running random traffic in parallel
  for (genvar gi = 0; gi < 2; gi++) begin : g_w
    localparam int unsigned GW = (gi == 0) ? 2 : 16;
    logic          g_rst_n;
    logic          g_iv;
    logic          g_ir;
    logic [GW-1:0] ga;
    logic [GW-1:0] gb;
    logic          g_ov;
    logic          g_or;
    logic [GW-1:0] gdiff;
    logic          gbout;
    logic          gbusy;
`ifdef SERIAL_SUB_OVF_EN
    logic          govf;
`endif
    bit            done;

    serial_subtractor #(.WIDTH(GW)) u_dut_w (
      .clk       (clk),
      .rst_n     (g_rst_n),
      .in_valid  (g_iv),
      .in_ready  (g_ir),
      .a         (ga),
      .b         (gb),
      .out_valid (g_ov),
      .out_ready (g_or),
      .diff      (gdiff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf       (govf),
`endif
      .bout      (gbout),
      .busy      (gbusy)
    );

    initial begin
      logic [GW-1:0] xa;
      logic [GW-1:0] xb;
      logic [GW-1:0] e_d;
      int            t;
      done    = 1'b0;
      g_rst_n = 1'b0;
      g_iv    = 1'b0;
      g_or    = 1'b0;
      ga      = '0;
      gb      = '0;
      repeat (2) @(posedge clk);
      #1 g_rst_n = 1'b1;
      for (int n = 0; n < 300; n++) begin
        xa = GW'($urandom);
        xb = GW'($urandom);
        if (n == 0) begin xa = '0; xb = GW'(1); end
        if (n == 1) begin xa = '1; xb = '1; end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        t = 0;
        while (!g_ir && t < 50) begin
          @(posedge clk); #1;
          t++;
        end
        g_iv = 1'b1;
        ga   = xa;
        gb   = xb;
        @(posedge clk); #1;
        g_iv = 1'b0;
        t = 0;
        while (!g_ov && t < 100) begin
          @(posedge clk); #1;
          t++;
        end
        check($sformatf("w%0d_valid", GW), 32'(g_ov), 32'd1);
        e_d = xa - xb;
        check($sformatf("w%0d_diff", GW), 32'(gdiff), 32'(e_d));
        check($sformatf("w%0d_bout", GW), 32'(gbout), 32'(xa < xb));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        g_or = 1'b1;
        @(posedge clk); #1;
        g_or = 1'b0;
      end
      done = 1'b1;
    end
  end

  // Main directed and random sequence on the WIDTH=8 instance
  initial begin
    logic [W-1:0] d;
    logic [W-1:0] hd;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         bo;
    logic         hb;
    logic         ov;
    int           lat;
    int           t;
    bit           ok;
    bit           hold_ok;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_bout",      32'(bout),      32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf",       32'(ovf),       32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic op with latency and in_ready-low window
    do_op(8'd100, 8'd37, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("lat_100_37",  32'(lat), 32'(W + 1));
    check("diff_100_37", 32'(d),   32'd63);
    check("bout_100_37", 32'(bo),  32'd0);
    check("ctl_100_37",  32'(ok),  32'd1);

    do_op(8'd5, 8'd9, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("diff_5_9", 32'(d),  32'hFC);
    check("bout_5_9", 32'(bo), 32'd1);
    do_op(8'd0, 8'd1, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("diff_0_1", 32'(d),  32'hFF);
    check("bout_0_1", 32'(bo), 32'd1);
    do_op(8'hFF, 8'hFF, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("diff_ff_ff", 32'(d),  32'd0);
    check("bout_ff_ff", 32'(bo), 32'd0);

    // Backpressure in DONE while a new op is offered
    in_valid = 1'b1;
    a = 8'd50;
    b = 8'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    hd = diff;
    hb = bout;
    check("bp_diff", 32'(hd), 32'd30);
    hold_ok  = 1'b1;
    in_valid = 1'b1;
    a = 8'd1;
    b = 8'd1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || busy || diff !== hd || bout !== hb) hold_ok = 1'b0;
    end
    check("bp_hold", 32'(hold_ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 32'(in_ready),  32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    check("bp_idle_busy",  32'(busy),      32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_new_diff", 32'(diff), 32'd0);
    check("bp_new_bout", 32'(bout), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the third RUN cycle discards the op
    in_valid = 1'b1;
    a = 8'd77;
    b = 8'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_busy",      32'(busy),      32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready",  32'(in_ready),  32'd1);
    check("mrst_diff",      32'(diff),      32'd0);
    do_op(8'd200, 8'd55, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("diff_200_55", 32'(d),  32'd145);
    check("bout_200_55", 32'(bo), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("ovf_80_01_diff", 32'(d),  32'h7F);
    check("ovf_80_01",      32'(ov), 32'd1);
    do_op(8'h7F, 8'hFF, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("ovf_7f_ff_diff", 32'(d),  32'h80);
    check("ovf_7f_ff",      32'(ov), 32'd1);
    do_op(8'h10, 8'h01, 0, 0, 1'b0, d, bo, ov, lat, ok);
    check("ovf_10_01",      32'(ov), 32'd0);
`endif

    // Random traffic with gaps, backpressure and ignored in_valid noise
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, d, bo, ov, lat, ok);
      check("rnd_diff", 32'(d),   32'(ref_diff(ra, rb)));
      check("rnd_bout", 32'(bo),  32'(ref_bout(ra, rb)));
      check("rnd_lat",  32'(lat), 32'(W + 1));
      check("rnd_ctl",  32'(ok),  32'd1);
`ifdef SERIAL_SUB_OVF_EN
      check("rnd_ovf",  32'(ov),  32'(ref_ovf(ra, rb)));
`endif
    end

    t = 0;
    while (!(g_w[0].done && g_w[1].done) && t < 60000) begin
      @(posedge clk); #1;
      t++;
    end
    check("width_runs_done", 32'(g_w[0].done && g_w[1].done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
